// File: rtl/onehot_encoder_pipe_if.sv
// Stream bundle for the one-hot encoder: one-hot words in, {index, err} out,
// plus the running error count.
interface onehot_encoder_pipe_if #(
    parameter int BITS      = 3,
    parameter int ERR_CNT_W = 8
);
    localparam int OUT_BITS = 1 << BITS;

    logic                 in_valid;
    logic                 in_ready;
    logic [OUT_BITS-1:0]  in_onehot;
    logic                 out_valid;
    logic                 out_ready;
    logic [BITS-1:0]      out_index;
    logic                 out_err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output in_valid, in_onehot, out_ready,
        input  in_ready, out_valid, out_index, out_err, err_count
    );

    modport slave (
        input  in_valid, in_onehot, out_ready,
        output in_ready, out_valid, out_index, out_err, err_count
    );
endinterface

// File: rtl/onehot_encoder_pipe.sv
// One-hot to binary encoder with zero/multi-hot detection, a 2-entry ordered
// output buffer and a saturating error counter.
module onehot_encoder_pipe #(
    parameter int BITS      = 3,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    onehot_encoder_pipe_if.slave bus
);
    localparam int OUT_BITS = 1 << BITS;
    localparam int ENTRY_W  = BITS + 1;

    // Entry layout: {index, err}; multi-hot words report the lowest set bit.
    function automatic logic [ENTRY_W-1:0] encode(input logic [OUT_BITS-1:0] w);
        logic [BITS-1:0] idx;
        logic            found;
        logic            multi;
        idx   = '0;
        found = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < OUT_BITS; i++) begin
            if (w[i]) begin
                if (found) begin
                    multi = 1'b1;
                end else begin
                    idx   = i[BITS-1:0];
                    found = 1'b1;
                end
            end
        end
        return {idx, (!found) || multi};
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
        return (&c) ? c : c + ERR_CNT_W'(1);
    endfunction

    logic [ENTRY_W-1:0]   mem_q [2];
    logic [ENTRY_W-1:0]   mem_d [2];
    logic                 rd_ptr_q, rd_ptr_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic [1:0]           count_q, count_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                 push;
    logic                 pop;
    logic                 out_valid;
    logic [ENTRY_W-1:0]   entry;
    logic [ENTRY_W-1:0]   head;

    assign out_valid = (count_q != 2'd0);
    assign entry     = encode(bus.in_onehot);
    assign head      = mem_q[rd_ptr_q];

    assign bus.in_ready  = rst_n && (count_q != 2'd2);
    assign bus.out_valid = out_valid;
    assign bus.out_index = out_valid ? head[ENTRY_W-1:1] : '0;
    assign bus.out_err   = out_valid ? head[0] : 1'b0;
    assign bus.err_count = err_cnt_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = out_valid && bus.out_ready;

    always_comb begin
        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = entry;
            wr_ptr_d        = ~wr_ptr_q;
            if (entry[0]) begin
                err_cnt_d = sat_inc(err_cnt_q);
            end
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Reset clears the stored entries too, so dropped words can never resurface.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            err_cnt_q <= '0;
        end else begin
            mem_q[0]  <= mem_d[0];
            mem_q[1]  <= mem_d[1];
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
        end
    end
endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Directed bench for onehot_encoder_pipe: an 8-bit-counter instance for the
// main behaviour and a 2-bit-counter instance for saturation.
module tb_onehot_encoder_pipe;
    logic clk;
    logic rst_n;

    onehot_encoder_pipe_if #(.BITS(3), .ERR_CNT_W(8)) ifa ();
    onehot_encoder_pipe_if #(.BITS(3), .ERR_CNT_W(2)) ifb ();

    onehot_encoder_pipe #(.BITS(3), .ERR_CNT_W(8)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    onehot_encoder_pipe #(.BITS(3), .ERR_CNT_W(2)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] err_vec [3];
    int         err_idx [3];

    initial begin
        err_vec[0] = 8'h00; err_idx[0] = 0;
        err_vec[1] = 8'h28; err_idx[1] = 3;
        err_vec[2] = 8'hFF; err_idx[2] = 0;

        rst_n         = 1'b0;
        ifa.in_valid  = 1'b0;
        ifa.in_onehot = 8'h00;
        ifa.out_ready = 1'b0;
        ifb.in_valid  = 1'b0;
        ifb.in_onehot = 8'h00;
        ifb.out_ready = 1'b0;

        step();
        step();
        chk("rst_in_ready",  32'(ifa.in_ready),  0);
        chk("rst_out_valid", 32'(ifa.out_valid), 0);
        chk("rst_out_index", 32'(ifa.out_index), 0);
        chk("rst_out_err",   32'(ifa.out_err),   0);
        chk("rst_err_count", 32'(ifa.err_count), 0);

        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(ifa.in_ready), 1);

        // Sweep of legal one-hot words, consumer always ready.
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ifa.in_valid  = 1'b1;
            ifa.in_onehot = 8'(1 << i);
            step();
            chk("sweep_valid", 32'(ifa.out_valid), 1);
            chk("sweep_index", 32'(ifa.out_index), 32'(i));
            chk("sweep_err",   32'(ifa.out_err),   0);
            chk("sweep_ready", 32'(ifa.in_ready),  1);
        end
        ifa.in_valid = 1'b0;
        step();
        chk("sweep_drain_valid", 32'(ifa.out_valid), 0);
        chk("sweep_drain_index", 32'(ifa.out_index), 0);
        chk("sweep_err_count",   32'(ifa.err_count), 0);

        // Zero-hot and multi-hot words.
        for (int k = 0; k < 3; k++) begin
            ifa.in_valid  = 1'b1;
            ifa.in_onehot = err_vec[k];
            step();
            chk("errw_valid", 32'(ifa.out_valid), 1);
            chk("errw_index", 32'(ifa.out_index), 32'(err_idx[k]));
            chk("errw_err",   32'(ifa.out_err),   1);
            chk("errw_count", 32'(ifa.err_count), 32'(k + 1));
        end
        ifa.in_valid = 1'b0;
        step();
        chk("errw_final_count", 32'(ifa.err_count), 3);
        chk("errw_drained",     32'(ifa.out_valid), 0);

        // Backpressure: fill both slots, then a push that must be ignored.
        ifa.out_ready = 1'b0;
        ifa.in_valid  = 1'b1;
        ifa.in_onehot = 8'h04;
        step();
        chk("bp1_index", 32'(ifa.out_index), 2);
        chk("bp1_ready", 32'(ifa.in_ready),  1);
        ifa.in_onehot = 8'h10;
        step();
        chk("bp2_ready", 32'(ifa.in_ready),  0);
        chk("bp2_index", 32'(ifa.out_index), 2);
        ifa.in_onehot = 8'h80;
        step();
        chk("bp_full_ready", 32'(ifa.in_ready),  0);
        chk("bp_full_valid", 32'(ifa.out_valid), 1);
        chk("bp_full_index", 32'(ifa.out_index), 2);
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;
        step();
        chk("bp_pop1_index", 32'(ifa.out_index), 4);
        chk("bp_pop1_ready", 32'(ifa.in_ready),  1);
        step();
        chk("bp_pop2_empty", 32'(ifa.out_valid), 0);

        // Simultaneous push and pop at occupancy 1.
        ifa.out_ready = 1'b0;
        ifa.in_valid  = 1'b1;
        ifa.in_onehot = 8'h02;
        step();
        chk("pp_head", 32'(ifa.out_index), 1);
        ifa.out_ready = 1'b1;
        ifa.in_onehot = 8'h40;
        step();
        chk("pp_valid", 32'(ifa.out_valid), 1);
        chk("pp_index", 32'(ifa.out_index), 6);
        chk("pp_ready", 32'(ifa.in_ready),  1);
        ifa.in_valid = 1'b0;
        step();
        chk("pp_single_left", 32'(ifa.out_valid), 0);

        // Reset with a full buffer and err_count = 5.
        ifa.out_ready = 1'b0;
        ifa.in_valid  = 1'b1;
        ifa.in_onehot = 8'h00;
        step();
        step();
        ifa.in_valid = 1'b0;
        chk("mr_count5", 32'(ifa.err_count), 5);
        chk("mr_full",   32'(ifa.in_ready),  0);
        rst_n         = 1'b0;
        ifa.out_ready = 1'b1;
        step();
        chk("mr_valid",    32'(ifa.out_valid), 0);
        chk("mr_index",    32'(ifa.out_index), 0);
        chk("mr_err_cnt",  32'(ifa.err_count), 0);
        chk("mr_in_ready", 32'(ifa.in_ready),  0);
        rst_n         = 1'b1;
        ifa.out_ready = 1'b0;
        ifa.in_valid  = 1'b1;
        ifa.in_onehot = 8'h08;
        step();
        chk("mr_next_valid", 32'(ifa.out_valid), 1);
        chk("mr_next_index", 32'(ifa.out_index), 3);
        chk("mr_next_err",   32'(ifa.out_err),   0);
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;
        step();
        chk("mr_no_stale", 32'(ifa.out_valid), 0);

        // Saturating 2-bit error counter.
        ifb.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ifb.in_valid  = 1'b1;
            ifb.in_onehot = 8'h00;
            step();
            chk("sat_count", 32'(ifb.err_count), (k < 3) ? 32'(k + 1) : 32'd3);
            chk("sat_err",   32'(ifb.out_err),   1);
        end
        ifb.in_valid = 1'b0;
        step();
        chk("sat_hold", 32'(ifb.err_count), 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
